// File: rtl/race_controller.sv
// race_controller: two-player drag-race start and finish controller.
// A start request runs a three-step lamp countdown, opens the race (go),
// then latches the first finish-line result or a timeout into DONE.
// Optional feature macro: FALSE_START_EN. When defined, a throttle input
// seen during the countdown is a false start and ends the race at once.
// When undefined, the gas inputs are ignored and false_start is tied to 00.
module race_controller #(
    parameter logic [31:0] STEP_CYCLES    = 32'd50_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       p1_gas,
    input  logic       p2_gas,
    input  logic       p1_finish,
    input  logic       p2_finish,
    output logic [2:0] lights,
    output logic       go,
    output logic [1:0] winner,
    output logic [1:0] false_start,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RACE      = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Terminal counter values; the counter always runs 0..N-1 for an N-cycle interval.
    localparam logic [31:0] STEP_LAST    = STEP_CYCLES - 32'd1;
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    localparam logic [2:0] LAMPS_OFF  = 3'b000;
    localparam logic [2:0] LAMPS_FIRST = 3'b001;
    localparam logic [2:0] LAMPS_FULL = 3'b111;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [2:0]  lights_q, lights_d;
    logic        go_q, go_d;
    logic [1:0]  winner_q, winner_d;
    logic        done_q, done_d;

    logic        finishSeen;
    logic        stepExpired;
    logic        raceExpired;
    logic [1:0]  finishResult;

    assign finishSeen   = p1_finish | p2_finish;
    assign stepExpired  = (count_q == STEP_LAST);
    assign raceExpired  = (count_q == TIMEOUT_LAST);
    assign finishResult = {p2_finish, p1_finish};

`ifdef FALSE_START_EN
    logic [1:0] falseStart_q, falseStart_d;
    logic       gasSeen;
    logic [1:0] gasWinner;

    assign gasSeen = p1_gas | p2_gas;

    // A lone offender hands the race to the other player; a double fault has no winner.
    always_comb begin
        gasWinner = WIN_NONE;
        if (p1_gas && !p2_gas) begin
            gasWinner = WIN_P2;
        end else if (p2_gas && !p1_gas) begin
            gasWinner = WIN_P1;
        end
    end
`else
    logic unusedGas;
    assign unusedGas = p1_gas ^ p2_gas;
`endif

    // Next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        lights_d = lights_q;
        go_d     = go_q;
        winner_d = winner_q;
        done_d   = done_q;
`ifdef FALSE_START_EN
        falseStart_d = falseStart_q;
`endif

        if (abort) begin
            state_d  = IDLE;
            count_d  = 32'd0;
            lights_d = LAMPS_OFF;
            go_d     = 1'b0;
            winner_d = WIN_NONE;
            done_d   = 1'b0;
`ifdef FALSE_START_EN
            falseStart_d = 2'b00;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    count_d = 32'd0;
                    if (start) begin
                        state_d  = COUNTDOWN;
                        lights_d = LAMPS_FIRST;
                        go_d     = 1'b0;
                        winner_d = WIN_NONE;
                        done_d   = 1'b0;
`ifdef FALSE_START_EN
                        falseStart_d = 2'b00;
`endif
                    end
                end

                COUNTDOWN: begin
`ifdef FALSE_START_EN
                    if (gasSeen) begin
                        state_d      = DONE;
                        count_d      = 32'd0;
                        lights_d     = LAMPS_OFF;
                        go_d         = 1'b0;
                        done_d       = 1'b1;
                        winner_d     = gasWinner;
                        falseStart_d = {p2_gas, p1_gas};
                    end else
`endif
                    if (stepExpired) begin
                        count_d = 32'd0;
                        if (lights_q == LAMPS_FULL) begin
                            state_d  = RACE;
                            lights_d = LAMPS_OFF;
                            go_d     = 1'b1;
                        end else begin
                            lights_d = {lights_q[1:0], 1'b1};
                        end
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end

                RACE: begin
                    if (finishSeen) begin
                        state_d  = DONE;
                        count_d  = 32'd0;
                        go_d     = 1'b0;
                        done_d   = 1'b1;
                        winner_d = finishResult;
                    end else if (raceExpired) begin
                        state_d  = DONE;
                        count_d  = 32'd0;
                        go_d     = 1'b0;
                        done_d   = 1'b1;
                        winner_d = WIN_NONE;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
                end

                default: begin
                    state_d  = IDLE;
                    count_d  = 32'd0;
                    lights_d = LAMPS_OFF;
                    go_d     = 1'b0;
                    done_d   = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 32'd0;
            lights_q <= LAMPS_OFF;
            go_q     <= 1'b0;
            winner_q <= WIN_NONE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lights_q <= lights_d;
            go_q     <= go_d;
            winner_q <= winner_d;
            done_q   <= done_d;
        end
    end

`ifdef FALSE_START_EN
    // False-start flags, kept until the next start, abort or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            falseStart_q <= 2'b00;
        end else begin
            falseStart_q <= falseStart_d;
        end
    end

    assign false_start = falseStart_q;
`else
    assign false_start = 2'b00;
`endif

    assign lights = lights_q;
    assign go     = go_q;
    assign winner = winner_q;
    assign done   = done_q;

    // WIN_TIE documents the both-finish encoding produced by finishResult.
    logic unusedTie;
    assign unusedTie = ^WIN_TIE;

endmodule

// File: tb/tb_race_controller.sv
// tb_race_controller: directed self-checking bench for race_controller
// with STEP_CYCLES=4 and TIMEOUT_CYCLES=20.
module tb_race_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       p1_gas;
    logic       p2_gas;
    logic       p1_finish;
    logic       p2_finish;
    logic [2:0] lights;
    logic       go;
    logic [1:0] winner;
    logic [1:0] false_start;
    logic       done;

    int checks = 0;
    int errors = 0;

    race_controller #(
        .STEP_CYCLES   (32'd4),
        .TIMEOUT_CYCLES(32'd20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .p1_gas     (p1_gas),
        .p2_gas     (p2_gas),
        .p1_finish  (p1_finish),
        .p2_finish  (p2_finish),
        .lights     (lights),
        .go         (go),
        .winner     (winner),
        .false_start(false_start),
        .done       (done)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic s, input logic a, input logic g1,
                                 input logic g2, input logic f1, input logic f2);
        start     = s;
        abort     = a;
        p1_gas    = g1;
        p2_gas    = g2;
        p1_finish = f1;
        p2_finish = f2;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: actual lights/go/winner/fs/done=%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b",
                   tag, obs[8:6], obs[5], obs[4:3], obs[2:1], obs[0],
                   exp[8:6], exp[5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic checkAll(input string tag, input logic [2:0] eLights, input logic eGo,
                            input logic [1:0] eWinner, input logic [1:0] eFs, input logic eDone);
        checkOutput(tag, {lights, go, winner, false_start, done},
                    {eLights, eGo, eWinner, eFs, eDone});
    endtask

    // Pulse start for one cycle, check the first countdown cycle, then run to race cycle 0.
    task automatic runToRace(input string tag);
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll(tag, 3'b001, 1'b0, 2'b00, 2'b00, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [2:0] expLights;

        applyStimulus(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        checkAll("reset_async", 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkAll("reset_held", 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checkAll("idle", 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);

        // Full countdown: 4 cycles per lamp step, start and finish ignored meanwhile.
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            expLights = (i < 4) ? 3'b001 : ((i < 8) ? 3'b011 : 3'b111);
            checkAll($sformatf("countdown_%0d", i), expLights, 1'b0, 2'b00, 2'b00, 1'b0);
            applyStimulus((i == 5), 0, 0, 0, (i == 7), 0);
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("go_first", 3'b000, 1'b1, 2'b00, 2'b00, 1'b0);

        // Player 2 finishes at race cycle 5; a later player 1 finish changes nothing.
        repeat (5) @(negedge clk);
        checkAll("race_cycle5", 3'b000, 1'b1, 2'b00, 2'b00, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkAll("p2_win", 3'b000, 1'b0, 2'b10, 2'b00, 1'b1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("p1_late", 3'b000, 1'b0, 2'b10, 2'b00, 1'b1);

        // Restart from DONE, then a simultaneous finish.
        runToRace("restart_done");
        checkAll("go_again", 3'b000, 1'b1, 2'b00, 2'b00, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("tie", 3'b000, 1'b0, 2'b11, 2'b00, 1'b1);

        // No finish: go lasts exactly 20 cycles, then timeout with no winner.
        runToRace("timeout_start");
        for (int i = 0; i < 20; i++) begin
            if (i == 19) begin
                checkAll("timeout_last", 3'b000, 1'b1, 2'b00, 2'b00, 1'b0);
            end
            @(negedge clk);
        end
        checkAll("timeout", 3'b000, 1'b0, 2'b00, 2'b00, 1'b1);

        // A finish on the timeout cycle wins over the timeout.
        runToRace("prio_start");
        repeat (19) @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("finish_over_timeout", 3'b000, 1'b0, 2'b01, 2'b00, 1'b1);

        // Abort from DONE clears the held result.
        applyStimulus(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("abort_done", 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);

        // Abort beats start in IDLE.
        applyStimulus(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("abort_over_start", 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);

        // Abort during RACE.
        runToRace("abort_race_start");
        repeat (2) @(negedge clk);
        applyStimulus(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("abort_race", 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);

        // Reset mid-countdown takes effect without a clock edge and discards progress.
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        checkAll("pre_reset", 3'b011, 1'b0, 2'b00, 2'b00, 1'b0);
        #1 reset = 1'b1;
        #1;
        checkAll("reset_mid_countdown", 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkAll("post_reset_idle", 3'b000, 1'b0, 2'b00, 2'b00, 1'b0);

`ifdef FALSE_START_EN
        // Player 1 jumps while lights=011; then both players jump together.
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        checkAll("fs_pre", 3'b011, 1'b0, 2'b00, 2'b00, 1'b0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("fs_p1", 3'b000, 1'b0, 2'b10, 2'b01, 1'b1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("fs_restart", 3'b001, 1'b0, 2'b00, 2'b00, 1'b0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("fs_both", 3'b000, 1'b0, 2'b00, 2'b11, 1'b1);
`else
        // Gas inputs have no effect when the false-start feature is absent.
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 1, 1, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("gas_ignored", 3'b001, 1'b0, 2'b00, 2'b00, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/race_controller.md
RACE_CONTROLLER -- requirements
Module: race_controller

Interface
REQ-001 Parameter STEP_CYCLES, default 50_000_000: clock cycles per countdown light step; legal range 1..2^32-1.
REQ-002 Parameter TIMEOUT_CYCLES, default 500_000_000: maximum race duration in clock cycles; legal range 1..2^32-1.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level; request a new race; sampled in IDLE and DONE only.
REQ-006 abort  input  1  level; synchronous return to IDLE from any state.
REQ-007 p1_gas, p2_gas  input  1 each  player throttle levels; used for false-start detection only.
REQ-008 p1_finish, p2_finish  input  1 each  player finish-line levels.
REQ-009 lights  output  3  countdown lamps as a thermometer code: 000, 001, 011, 111.
REQ-010 go  output  1  high for the whole RACE state.
REQ-011 winner  output  2  00 = none or timeout, 01 = player 1, 10 = player 2, 11 = tie.
REQ-012 false_start  output  2  bit0 = player 1 fault, bit1 = player 2 fault.
REQ-013 done  output  1  high while a result is held in DONE.

Function
REQ-014 The controller SHALL implement the states IDLE, COUNTDOWN, RACE and DONE, with all outputs registered.
REQ-015 The controller SHALL use one 32-bit cycle counter, cleared on every state entry and on every light step.
REQ-016 IDLE: outputs SHALL be lights=000, go=0 and done=0; winner and false_start SHALL hold their previous values.
REQ-017 IDLE: start=1 SHALL cause the next state to be COUNTDOWN, with lights=001, winner=00 and false_start=00.
REQ-018 COUNTDOWN: when the counter reaches STEP_CYCLES-1, lights SHALL advance 001->011->111 and the counter SHALL clear.
REQ-019 COUNTDOWN: when the counter reaches STEP_CYCLES-1 with lights=111, the next state SHALL be RACE, with lights=000 and go=1.
REQ-020 The total countdown SHALL last exactly 3*STEP_CYCLES cycles, from the first cycle with lights=001 to the first cycle with go=1.
REQ-021 RACE: the first cycle in which p1_finish or p2_finish is high SHALL load winner and move to DONE on the next edge.
REQ-022 RACE finish result: only p1_finish high -> winner=01; only p2_finish high -> winner=10; both high in the same cycle -> winner=11.
REQ-023 RACE: when the counter reaches TIMEOUT_CYCLES-1 with no finish seen, the controller SHALL load winner=00 and move to DONE.
REQ-024 RACE: a finish in the same cycle as the timeout SHALL take priority over the timeout.
REQ-025 DONE: outputs SHALL be done=1, go=0 and lights=000; winner and false_start SHALL be held.
REQ-026 DONE: start=1 SHALL restart exactly as from IDLE (REQ-017).
REQ-027 start SHALL be ignored in COUNTDOWN and RACE.
REQ-028 Finish inputs SHALL be ignored outside RACE.
REQ-029 abort=1 SHALL force IDLE on the next edge from any state, with priority over every other input, clearing winner and false_start.
REQ-030 Each state transition SHALL appear on the outputs one cycle after the input that caused it is sampled.

Reset
REQ-031 While reset=1, the controller SHALL be in IDLE with counter=0, lights=000, go=0, winner=00, false_start=00 and done=0, independent of clk.
REQ-032 Reset asserted mid-COUNTDOWN or mid-RACE SHALL discard all progress; after release, start is required to begin again.

Configuration
REQ-033 With macro FALSE_START_EN defined, pN_gas=1 in any COUNTDOWN cycle SHALL set false_start bit N, move to DONE on the next edge and award winner to the other player.
REQ-034 With FALSE_START_EN defined, both gas inputs high in the same COUNTDOWN cycle SHALL give false_start=11, winner=00 and a move to DONE.
REQ-035 With FALSE_START_EN undefined, the gas inputs SHALL be ignored, false_start SHALL be constant 00, and no related logic SHALL be synthesized.

Verification (STEP_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-036 reset, then a 1-cycle start pulse -> lights 001/011/111 for 4 cycles each, go=1 exactly 12 cycles after lights first equals 001.
REQ-037 In RACE, p2_finish=1 at race cycle 5 -> winner=10 and done=1 on the next edge; a later p1_finish leaves winner=10.
REQ-038 In RACE, p1_finish and p2_finish high in the same cycle -> winner=11; no finish for 20 cycles -> winner=00 and done=1.
REQ-039 FALSE_START_EN defined, p1_gas=1 while lights=011 -> false_start=01, winner=10, done=1; both gas inputs high together -> false_start=11, winner=00.
REQ-040 abort=1 during RACE -> IDLE with go=0 and winner=00 next cycle; reset asserted mid-COUNTDOWN -> all outputs at reset values immediately.
